data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Data-memory port of the pipelined RISC-V core (MEM stage).
- Converts single 32-bit word load/store requests into two sequential 16-bit accesses on an external asynchronous SRAM (256K x 16, active-low controls).
- Holds the pipeline with o_stall until the word transfer completes.

Parameters:
- SRAM_AW, 18, SRAM address width (word address = i_addr[SRAM_AW:2]).
- WAIT_CYCLES, 1, extra cycles per half-word access; used only when DATA_MEM_WAIT_EN is defined.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_addr  in  32  byte address; bits [1:0] and above [18] ignored.
- i_data  in  32  store data.
- i_rden  in  1  load request, level; held until o_stall low.
- i_wren  in  1  store request, level; held until o_stall low.
- o_data  out  32  load result, registered.
- o_stall  out  1  high while the request is in progress.
- o_SRAM_ADDR  out  18  SRAM half-word address.
- o_SRAM_DQ  inout  16  SRAM data bus.
- o_SRAM_CE_N  out  1  chip enable, active low.
- o_SRAM_WE_N  out  1  write enable, active low.
- o_SRAM_OE_N  out  1  output enable, active low.
- o_SRAM_LB_N  out  1  lower byte enable, active low.
- o_SRAM_UB_N  out  1  upper byte enable, active low.

Behaviour:
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Transitions:
  - IDLE -> WR_LO if i_wren; else RD_LO if i_rden; else stay IDLE. Write wins when both are high.
  - RD_LO -> RD_HI -> DONE.
  - WR_LO -> WR_HI -> DONE.
  - DONE -> IDLE.
- Address: o_SRAM_ADDR = {i_addr[18:2], half}; half = 0 in *_LO, 1 in *_HI. Value is 0 in IDLE/DONE.
- RD_LO/RD_HI: CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ released (Z). At the clock edge leaving the state, DQ is captured into o_data[15:0] (LO) or o_data[31:16] (HI).
- WR_LO/WR_HI: CE_N=0, WE_N=0, OE_N=1, LB_N=UB_N=0. DQ driven with i_data[15:0] (LO) or i_data[31:16] (HI).
- IDLE/DONE: CE_N=WE_N=OE_N=LB_N=UB_N=1, DQ Z.
- DQ is driven only in WR_LO/WR_HI; never driven while OE_N=0.
- o_stall is combinational: (i_rden | i_wren) & (state != DONE).
  - Cycle 0 (IDLE with request): stall high.
  - Cycles 1–2 (LO, HI): stall high.
  - Cycle 3 (DONE): stall low; o_data is valid here for reads.
  - Stall is low in IDLE when no request is present.
- A request still asserted in the cycle after DONE starts a new access (re-execution). The pipeline is responsible for dropping it.
- o_data holds its value until the next read's captures; writes do not change it.
- Request inputs change only while o_stall is low. The FSM does not re-sample i_addr/i_data mid-access; it uses live values.
- Reset (any time, including mid-access): state=IDLE, o_data=0, all SRAM controls high, DQ Z, immediately and asynchronously.

Optional Feature:
- Macro DATA_MEM_WAIT_EN.
- Defined: each LO/HI state is held for 1+WAIT_CYCLES cycles via a down-counter. Signals stay stable for the whole period; read capture happens on the last cycle. Total stall = 1 + 2*(1+WAIT_CYCLES) cycles.
- Undefined: one cycle per half, 3 stall cycles, counter logic absent.

Test Plan:
- Reset then idle: i_rst=1 -> o_data=0, CE_N/WE_N/OE_N/LB_N/UB_N=1, DQ Z, o_stall=0 with no request.
- Read 0x2000, bench drives DQ=0xFFFF -> addresses 0x1000 then 0x1001 with OE_N=0; o_data=0xFFFFFFFF in DONE; stall high exactly 3 cycles.
- Write 0x2000 data 0x1111FFFF -> addr 0x1000 DQ=0xFFFF WE_N=0, then 0x1001 DQ=0x1111; stall high 3 cycles; o_data unchanged.
- Write 0x3000 data 0x2222FFFF, then read 0x3000 with SRAM model -> writes at 0x1800/0x1801; read returns 0x2222FFFF.
- Write 0x0800 data 0x3333FFFF with i_rden=i_wren=1 -> write path taken, addrs 0x0400/0x0401, OE_N stays 1.
- Assert i_rst during RD_HI -> immediate IDLE, controls high, o_data=0; with DATA_MEM_WAIT_EN and WAIT_CYCLES=1, a read stalls 5 cycles.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: MEM-stage data port of the pipelined RISC-V core.
// Splits one 32-bit load/store into two 16-bit accesses on an external
// asynchronous SRAM (256K x 16, active-low controls) and holds the pipeline
// with o_stall until the word transfer has completed.
// Optional build macro DATA_MEM_WAIT_EN: stretches each half-word access to
// 1+WAIT_CYCLES cycles using a down-counter.
module data_mem #(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_data,
    input  logic               i_rden,
    input  logic               i_wren,
    output logic [31:0]        o_data,
    output logic               o_stall,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]        o_SRAM_DQ,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        half_done_c;
    logic        dq_oe_c;
    logic [15:0] dq_out_c;

`ifdef DATA_MEM_WAIT_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A half-word phase ends once the wait counter has run down to zero
    assign half_done_c = (cnt_q == '0);

    // Reload the counter on every state change, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Wait counter register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:SRAM_AW+1], i_addr[1:0]};
`else
    // Every half-word phase lasts exactly one cycle
    assign half_done_c = 1'b1;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:SRAM_AW+1], i_addr[1:0], 32'(WAIT_CYCLES)};
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a store wins when both requests are raised together
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_wren) begin
                    state_d = WR_LO;
                end else if (i_rden) begin
                    state_d = RD_LO;
                end
            end
            RD_LO: if (half_done_c) state_d = RD_HI;
            RD_HI: if (half_done_c) state_d = DONE;
            WR_LO: if (half_done_c) state_d = WR_HI;
            WR_HI: if (half_done_c) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM control, address and write-data decode from the current state
    always_comb begin
        o_SRAM_CE_N = 1'b1;
        o_SRAM_WE_N = 1'b1;
        o_SRAM_OE_N = 1'b1;
        o_SRAM_LB_N = 1'b1;
        o_SRAM_UB_N = 1'b1;
        o_SRAM_ADDR = '0;
        dq_oe_c     = 1'b0;
        dq_out_c    = '0;
        case (state_q)
            RD_LO, RD_HI: begin
                o_SRAM_CE_N = 1'b0;
                o_SRAM_OE_N = 1'b0;
                o_SRAM_LB_N = 1'b0;
                o_SRAM_UB_N = 1'b0;
                o_SRAM_ADDR = {i_addr[SRAM_AW:2], (state_q == RD_HI)};
            end
            WR_LO, WR_HI: begin
                o_SRAM_CE_N = 1'b0;
                o_SRAM_WE_N = 1'b0;
                o_SRAM_LB_N = 1'b0;
                o_SRAM_UB_N = 1'b0;
                o_SRAM_ADDR = {i_addr[SRAM_AW:2], (state_q == WR_HI)};
                dq_oe_c     = 1'b1;
                dq_out_c    = (state_q == WR_HI) ? i_data[31:16] : i_data[15:0];
            end
            default: begin
            end
        endcase
    end

    // Data bus is driven only during the two write phases
    assign o_SRAM_DQ = dq_oe_c ? dq_out_c : 16'hzzzz;

    // Pipeline hold: released only in DONE so the core sees the result there
    assign o_stall = (i_rden | i_wren) & (state_q != DONE);

    // Load result: capture each half on the last cycle of its read phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (half_done_c) begin
            if (state_q == RD_LO) begin
                o_data[15:0] <= o_SRAM_DQ;
            end else if (state_q == RD_HI) begin
                o_data[31:16] <= o_SRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem with a behavioural SRAM and
// a word-level reference memory.
`timescale 1ns/1ps
module tb_data_mem;

    localparam int unsigned TB_WAIT = 1;
`ifdef DATA_MEM_WAIT_EN
    localparam int unsigned PER_HALF = 1 + TB_WAIT;
`else
    localparam int unsigned PER_HALF = 1;
`endif
    localparam int unsigned STALL_CYC = 1 + 2 * PER_HALF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_rden;
    logic        i_wren;
    logic [31:0] o_data;
    logic        o_stall;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem #(.SRAM_AW(18), .WAIT_CYCLES(TB_WAIT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_rden      (i_rden),
        .i_wren      (i_wren),
        .o_data      (o_data),
        .o_stall     (o_stall),
        .o_SRAM_ADDR (sram_addr),
        .o_SRAM_DQ   (sram_dq),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    // Behavioural SRAM: drives read data when selected, otherwise holds the
    // bus at zero whenever WE_N is high so a stray DUT driver shows up.
    bit   [15:0] sram [0:262143];
    logic        force_ffff = 1'b0;
    logic [15:0] rd_val;
    always_comb rd_val = force_ffff ? 16'hFFFF : sram[sram_addr];
    assign sram_dq = we_n ? ((!ce_n && !oe_n) ? rd_val : 16'h0000) : 16'hzzzz;
    always @(posedge clk) if (!ce_n && !we_n) sram[sram_addr] <= sram_dq;

    // Word-level reference memory (unwritten words read as zero)
    logic [31:0] ref_mem [int unsigned];
    function automatic logic [31:0] ref_read(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One word transfer; starts and ends at posedge+1
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input string tag,
                          output logic [31:0] rdata);
        int unsigned stall_n = 0;
        int unsigned rec     = 0;
        logic        ok      = 1'b1;
        logic        done    = 1'b0;
        logic        half;
        logic [17:0] exp_addr;
        i_rden = rd; i_wren = wr; i_addr = addr; i_data = data;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (o_stall) begin
                stall_n++;
                if (!ce_n) begin
                    half     = (rec >= PER_HALF);
                    exp_addr = {addr[18:2], half};
                    if (sram_addr !== exp_addr || lb_n !== 1'b0 || ub_n !== 1'b0) ok = 1'b0;
                    if (wr) begin
                        if (we_n !== 1'b0 || oe_n !== 1'b1 ||
                            sram_dq !== (half ? data[31:16] : data[15:0])) ok = 1'b0;
                    end else begin
                        if (we_n !== 1'b1 || oe_n !== 1'b0) ok = 1'b0;
                    end
                    rec++;
                end
            end else begin
                done = 1'b1;
            end
        end
        check({tag, " finished"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, stall_n, STALL_CYC);
        check({tag, " sram phases"}, rec, 2 * PER_HALF);
        check({tag, " sram signals"}, 32'(ok), 32'd1);
        rdata = o_data;
        @(posedge clk); #1;
        i_rden = 1'b0; i_wren = 1'b0;
    endtask

    // Bounded wait for the DONE cycle (stall low); returns at that negedge
    task automatic wait_done(input string tag);
        logic done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!o_stall) done = 1'b1;
        end
        check({tag, " finished"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        force_rd;
        logic [31:0] exp_odata;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] got;
    logic [31:0] exp_od;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,          1'b1, 32'hFFFF_FFFF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h1111_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_3000, 32'h2222_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,          1'b0, 32'h2222_FFFF};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0800, 32'h3333_FFFF, 1'b0, 32'h2222_FFFF};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0800, 32'h0,          1'b0, 32'h3333_FFFF};
        vecs[6] = '{1'b1, 1'b0, 32'hFFF8_2001, 32'h0,          1'b0, 32'h1111_FFFF};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          1'b0, 32'h0000_0000};

        rst = 1'b1; i_rden = 1'b0; i_wren = 1'b0;
        i_addr = 32'h0000_2000; i_data = 32'hA5A5_5A5A;
        repeat (2) @(posedge clk);
        #1;
        check("reset o_data", o_data, 32'h0);
        check("reset controls", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        check("reset dq released", {16'h0, sram_dq}, 32'h0);
        check("reset addr", {14'h0, sram_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle stall", {31'h0, o_stall}, 32'h0);
        check("idle controls", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            force_ffff = vecs[i].force_rd;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   $sformatf("vec%0d", i), got);
            force_ffff = 1'b0;
            if (vecs[i].wr) ref_mem[int'(vecs[i].addr[18:2])] = vecs[i].data;
            check($sformatf("vec%0d o_data", i), got, vecs[i].exp_odata);
        end
        check("sram 0x1800", {16'h0, sram[18'h1800]}, 32'h0000_FFFF);
        check("sram 0x1801", {16'h0, sram[18'h1801]}, 32'h0000_2222);
        check("sram 0x0400", {16'h0, sram[18'h0400]}, 32'h0000_FFFF);
        check("sram 0x0401", {16'h0, sram[18'h0401]}, 32'h0000_3333);

        // Re-execution: a request held past DONE starts a fresh access
        i_rden = 1'b1; i_addr = 32'h0000_3000;
        wait_done("reexec first");
        check("reexec first data", o_data, 32'h2222_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("reexec idle stall", {31'h0, o_stall}, 32'h1);
        check("reexec idle ce_n", {31'h0, ce_n}, 32'h1);
        @(negedge clk);
        check("reexec restart", {30'h0, ce_n, oe_n}, 32'h0);
        wait_done("reexec second");
        check("reexec second data", o_data, 32'h2222_FFFF);
        @(posedge clk); #1;
        i_rden = 1'b0;

        // Asynchronous reset in the middle of RD_HI
        i_rden = 1'b1; i_addr = 32'h0000_2000;
        repeat (2 + PER_HALF) @(negedge clk);
        check("pre-reset in rd_hi", {13'h0, ce_n, sram_addr}, 32'h0000_1001);
        #1 rst = 1'b1;
        #1;
        check("mid reset controls", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        check("mid reset o_data", o_data, 32'h0);
        check("mid reset addr", {14'h0, sram_addr}, 32'h0);
        i_rden = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post reset idle", {26'h0, o_stall, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h0000_3000, 32'h0, "post reset read", got);
        check("post reset read data", got, 32'h2222_FFFF);

        // Randomized traffic against the reference memory
        exp_od = got;
        for (int t = 0; t < 60; t++) begin
            int unsigned op  = $urandom_range(0, 2);
            int unsigned idx = 32'h100 + $urandom_range(0, 15);
            logic [31:0] a   = ($urandom & 32'hFFF8_0003) | (idx << 2);
            logic [31:0] d   = $urandom;
            logic        wr  = (op != 0);
            logic        rd  = (op != 1);
            access(rd, wr, a, d, $sformatf("rnd%0d", t), got);
            if (wr) ref_mem[idx] = d;
            else    exp_od = ref_read(idx);
            check($sformatf("rnd%0d o_data", t), got, exp_od);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
